// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//
// Turns a valid/ready command stream into APB3/APB4 transfers and returns
// exactly one response per command.
//
// Ports:
//   clk, rst            clock (posedge) and asynchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_write, cmd_addr, cmd_wdata,
//                       cmd_strb carry the command
//   rsp_valid/ready     response handshake; rsp_rdata, rsp_err, rsp_timeout
//                       carry the result of the oldest finished command
//   busy                commands queued or a transfer in progress
//   paddr .. pstrb      APB request outputs (all registered)
//   prdata, pready,     APB completion inputs
//   pslverr
//
// Handshakes: a transfer on cmd_* or rsp_* happens on a rising clk edge
// where valid && ready are both high; valid holds its payload until then.

`timescale 1ns/1ps

module apb_cmd_master #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 16,
    parameter int APB4      = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic [ADDR_W-1:0]     paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_W-1:0]     pwdata,
    output logic [DATA_W/8-1:0]   pstrb,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(CMD_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(CMD_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Command FIFO storage is not reset: emptiness is tracked by count_q.
    logic              fifo_write_q [CMD_DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q  [CMD_DEPTH];
    logic [DATA_W-1:0] fifo_wdata_q [CMD_DEPTH];
    logic [STRB_W-1:0] fifo_strb_q  [CMD_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              psel_q, penable_q, pwrite_q;
    logic [ADDR_W-1:0] paddr_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [STRB_W-1:0] pstrb_q;
    logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    logic push, pop, done, abort;

    // Full is judged from the registered count only, so a pop in the same
    // cycle never lets a push into a full FIFO.
    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign busy      = (count_q != '0) || (state_q != S_IDLE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Only start when the response slot is free (or freeing now).
                if ((count_q != '0) && (!rsp_valid_q || rsp_ready)) begin
                    pop     = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                // pready wins over a timeout reached in the same cycle.
                if (pready) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if ((TIMEOUT != 0) && (wait_q == WAIT_LIMIT)) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Wait counter: zero on the first ACCESS cycle, counts pready-low cycles.
    always_comb begin
        wait_d = wait_q;
        if (state_q == S_SETUP) begin
            wait_d = '0;
        end else if ((state_q == S_ACCESS) && !pready && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_write_q[wr_ptr_q] <= cmd_write;
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
            fifo_strb_q[wr_ptr_q]  <= cmd_strb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (pop) begin
                psel_q    <= 1'b1;
                penable_q <= 1'b0;
                paddr_q   <= fifo_addr_q[rd_ptr_q];
                pwrite_q  <= fifo_write_q[rd_ptr_q];
                pwdata_q  <= fifo_wdata_q[rd_ptr_q];
                pstrb_q   <= ((APB4 != 0) && fifo_write_q[rd_ptr_q]) ? fifo_strb_q[rd_ptr_q] : '0;
            end else if (state_q == S_SETUP) begin
                penable_q <= 1'b1;
            end else if (done || abort) begin
                psel_q    <= 1'b0;
                penable_q <= 1'b0;
            end

            if (done) begin
                rsp_valid_q   <= 1'b1;
                rsp_err_q     <= pslverr;
                rsp_timeout_q <= 1'b0;
                rsp_rdata_q   <= pwrite_q ? '0 : prdata;
            end else if (abort) begin
                rsp_valid_q   <= 1'b1;
                rsp_err_q     <= 1'b1;
                rsp_timeout_q <= 1'b1;
                rsp_rdata_q   <= '0;
            end else if (rsp_valid_q && rsp_ready) begin
                rsp_valid_q   <= 1'b0;
            end
        end
    end

    assign paddr       = paddr_q;
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps

module tb_apb_cmd_master;
  localparam logic [11:0] HANG_ADDR = 12'hFFC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_write, rsp_ready;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [31:0] prdata;
  logic        pready, pslverr;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, psel, penable, pwrite;
  logic [31:0] rsp_rdata, pwdata;
  logic [11:0] paddr;
  logic [3:0]  pstrb;

  logic        cmd_ready_b, rsp_valid_b, rsp_err_b, rsp_timeout_b, busy_b, psel_b, penable_b, pwrite_b;
  logic [31:0] rsp_rdata_b, pwdata_b;
  logic [11:0] paddr_b;
  logic [3:0]  pstrb_b;

  apb_cmd_master #(.ADDR_W(12), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT(16), .APB4(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // APB3 flavour fed the same stimulus; it must behave identically except pstrb == 0.
  apb_cmd_master #(.ADDR_W(12), .DATA_W(32), .CMD_DEPTH(4), .TIMEOUT(16), .APB4(0)) dut_apb3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .rsp_valid(rsp_valid_b),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b), .rsp_timeout(rsp_timeout_b),
    .busy(busy_b), .paddr(paddr_b), .psel(psel_b), .penable(penable_b), .pwrite(pwrite_b), .pwdata(pwdata_b),
    .pstrb(pstrb_b), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- slave model ----------------
  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  int cfg_wait = 0;
  bit cfg_err  = 1'b0;
  int acc_cyc  = 0;

  // HANG_ADDR never answers; other addresses answer after cfg_wait wait states.
  always @(negedge clk) begin
    prdata = $urandom;
    if (psel && penable) begin
      pready  = (paddr != HANG_ADDR) && (acc_cyc >= cfg_wait);
      pslverr = pready && cfg_err;
      if (pready && !pwrite) prdata = mem[paddr];
      acc_cyc++;
    end else begin
      pready  = 1'($urandom_range(0, 1));
      pslverr = 1'($urandom_range(0, 1));
      acc_cyc = 0;
    end
  end

  always @(posedge clk)
    if (!rst && psel && penable && pready && pwrite && !pslverr) mem[paddr] <= pwdata;

  // ---------------- monitor / scoreboard ----------------
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } rsp_t;

  typedef struct {
    logic [11:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    int          len;
    int          start;
  } xfer_t;

  rsp_t  exp_q[$];
  rsp_t  got_q[$];
  int    got_t[$];
  xfer_t rec_q[$];
  xfer_t cur;
  int    cur_len = 0;
  int    cyc = 0;
  int    stab_viol = 0;
  int    prot_viol = 0;
  int    b_strb_viol = 0;
  int    b_diff = 0;
  int    last_acc_cyc = 0;
  bit    rand_rdy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      cur_len = 0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        got_q.push_back({rsp_rdata, rsp_err, rsp_timeout});
        got_t.push_back(cyc);
      end
      if (psel) begin
        if (cur_len == 0) begin
          cur.addr = paddr; cur.wr = pwrite; cur.strb = pstrb; cur.wdata = pwdata; cur.start = cyc;
          if (penable) prot_viol++;
        end else begin
          if (paddr != cur.addr || pwrite != cur.wr || pstrb != cur.strb || pwdata != cur.wdata) stab_viol++;
          if (!penable) prot_viol++;
        end
        cur_len++;
      end else begin
        if (penable) prot_viol++;
        if (cur_len != 0) begin
          cur.len = cur_len;
          rec_q.push_back(cur);
          cur_len = 0;
        end
      end
      if (pstrb_b != 4'h0) b_strb_viol++;
      if ({cmd_ready_b, rsp_valid_b, rsp_err_b, rsp_timeout_b, busy_b, psel_b, penable_b, pwrite_b,
           rsp_rdata_b, pwdata_b, paddr_b} !==
          {cmd_ready, rsp_valid, rsp_err, rsp_timeout, busy, psel, penable, pwrite,
           rsp_rdata, pwdata, paddr}) b_diff++;
    end
  end

  always @(posedge clk) if (rand_rdy) begin #1; rsp_ready = 1'($urandom_range(0, 1)); end

  // Reference: commands complete in order; a slave error leaves memory untouched.
  function automatic rsp_t model_rsp(input bit wr, input logic [11:0] a, input logic [31:0] d);
    rsp_t r;
    if (a == HANG_ADDR) begin
      r = {32'h0, 1'b1, 1'b1};
    end else if (wr) begin
      if (!cfg_err) ref_mem[a] = d;
      r = {32'h0, cfg_err, 1'b0};
    end else begin
      r = {ref_mem[a], cfg_err, 1'b0};
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input bit wr, input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int  n  = 0;
    bit  ok = 1'b0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_strb = s;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    cmd_valid = 1'b0;
    last_acc_cyc = cyc;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL push_accept addr=%h: cmd_ready never seen within %0d cycles", a, n);
    end else begin
      exp_q.push_back(model_rsp(wr, a, d));
    end
  endtask

  task automatic wait_rsp(input int n, input int budget, input string tag);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (got_q.size() < n) begin
      n_fail++;
      $display("FAIL %s_rsp_count got %0d responses, expected %0d", tag, got_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    rsp_ready = 1'b0;
    idle(3);
    n_checks++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h pstrb=%h rv=%b rd=%h err=%b tmo=%b, expected all 0",
               psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status got cmd_ready=%b busy=%b, expected 1 0", cmd_ready, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write_read;
    rsp_t e, g;
    int   t0;
    cfg_wait = 0; cfg_err = 1'b0; rsp_ready = 1'b1;
    got_q.delete(); got_t.delete(); rec_q.delete();
    push_cmd(1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
    t0 = last_acc_cyc;
    push_cmd(1'b0, 12'h004, 32'h0, 4'hF);
    wait_rsp(2, 50, "wr_rd");
    idle(2);
    n_checks++;
    if (got_q.size() >= 2 && got_q[1].rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL wr_rd_rdata got %h, expected deadbeef", got_q[1].rdata);
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL wr_rd_rsp got %h, expected %h", g, e); end
    end
    n_checks++;
    if (rec_q.size() != 2 || rec_q[0].len != 2 || rec_q[1].len != 2) begin
      n_fail++;
      $display("FAIL wr_rd_psel_len got %0d transfers (len0=%0d), expected 2 of length 2",
               rec_q.size(), (rec_q.size() > 0) ? rec_q[0].len : -1);
    end
    n_checks++;
    if (rec_q.size() == 0 || rec_q[0].start - t0 != 2) begin
      n_fail++;
      $display("FAIL push_to_psel latency got %0d, expected 2", (rec_q.size() > 0) ? rec_q[0].start - t0 : -1);
    end
  endtask

  task automatic test_wait_err;
    rsp_t e, g;
    cfg_wait = 3; cfg_err = 1'b1; rsp_ready = 1'b1;
    got_q.delete(); rec_q.delete(); stab_viol = 0;
    push_cmd(1'b0, 12'h010, 32'h0, 4'h0);
    push_cmd(1'b1, 12'h014, $urandom, 4'hF);
    wait_rsp(2, 60, "wait_err");
    idle(2);
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL wait_err_rsp got %h, expected %h", g, e); end
    end
    n_checks++;
    if (rec_q.size() != 2 || rec_q[0].len != 5 || rec_q[1].len != 5) begin
      n_fail++;
      $display("FAIL wait_err_psel_len got %0d transfers (len0=%0d), expected 2 of length 5",
               rec_q.size(), (rec_q.size() > 0) ? rec_q[0].len : -1);
    end
    n_checks++;
    if (stab_viol != 0) begin n_fail++; $display("FAIL wait_err_stability got %0d changes, expected 0", stab_viol); end
    cfg_wait = 0; cfg_err = 1'b0;
  endtask

  task automatic test_timeout;
    rsp_t e, g;
    rsp_ready = 1'b1;
    got_q.delete(); rec_q.delete(); stab_viol = 0;
    push_cmd(1'b0, HANG_ADDR, 32'h0, 4'h0);
    push_cmd(1'b1, 12'h020, $urandom, 4'hF);
    push_cmd(1'b0, 12'h020, 32'h0, 4'h0);
    wait_rsp(3, 100, "timeout");
    idle(2);
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL timeout_rsp got %h, expected %h", g, e); end
    end
    n_checks++;
    if (rec_q.size() != 3 || rec_q[0].len != 18 || rec_q[1].len != 2) begin
      n_fail++;
      $display("FAIL timeout_psel_len got %0d transfers (len0=%0d), expected first 18 then 2",
               rec_q.size(), (rec_q.size() > 0) ? rec_q[0].len : -1);
    end
    n_checks++;
    if (stab_viol != 0) begin n_fail++; $display("FAIL timeout_stability got %0d changes, expected 0", stab_viol); end
  endtask

  task automatic test_backpressure;
    rsp_t e, g;
    bit   leaked = 1'b0;
    rsp_ready = 1'b0;
    got_q.delete(); got_t.delete(); rec_q.delete();
    for (int i = 0; i < 5; i++) push_cmd(i[0], 12'h100 + 12'(4 * i), $urandom, 4'hF);
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_full got cmd_ready=%b busy=%b, expected 0 1", cmd_ready, busy);
    end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h1F0; cmd_wdata = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0) leaked = 1'b1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_checks++;
    if (leaked) begin n_fail++; $display("FAIL bp_ready_held got cmd_ready=1 while full, expected 0"); end
    idle(8);
    n_checks++;
    if (rec_q.size() != 1 || got_q.size() != 0 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall got transfers=%0d handshakes=%0d rsp_valid=%b, expected 1 0 1",
               rec_q.size(), got_q.size(), rsp_valid);
    end
    rsp_ready = 1'b1;
    wait_rsp(5, 100, "bp");
    idle(6);
    for (int i = 1; i < 5 && i < got_t.size(); i++) begin
      n_checks++;
      if (got_t[i] - got_t[i-1] != 3) begin
        n_fail++;
        $display("FAIL bp_spacing rsp %0d got %0d cycles, expected 3", i, got_t[i] - got_t[i-1]);
      end
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL bp_rsp got %h, expected %h", g, e); end
    end
    n_checks++;
    if (got_q.size() != 0) begin n_fail++; $display("FAIL bp_extra got %0d extra responses, expected 0", got_q.size()); end
  endtask

  task automatic test_apb4_strb;
    rsp_t e, g;
    rsp_ready = 1'b1;
    got_q.delete(); rec_q.delete(); stab_viol = 0;
    push_cmd(1'b1, 12'h030, $urandom, 4'b0101);
    push_cmd(1'b0, 12'h030, 32'h0, 4'b1111);
    wait_rsp(2, 50, "strb");
    idle(2);
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL strb_rsp got %h, expected %h", g, e); end
    end
    n_checks++;
    if (rec_q.size() != 2 || rec_q[0].strb !== 4'b0101 || rec_q[1].strb !== 4'b0000) begin
      n_fail++;
      $display("FAIL apb4_pstrb got %0d transfers strb0=%b, expected 0101 then 0000",
               rec_q.size(), (rec_q.size() > 0) ? rec_q[0].strb : 4'bx);
    end
    n_checks++;
    if (stab_viol != 0) begin n_fail++; $display("FAIL strb_stability got %0d changes, expected 0", stab_viol); end
    n_checks++;
    if (b_strb_viol != 0) begin n_fail++; $display("FAIL apb3_pstrb got %0d nonzero cycles, expected 0", b_strb_viol); end
  endtask

  task automatic test_random;
    rsp_t e, g;
    logic [11:0] a;
    cfg_wait = $urandom_range(0, 3); cfg_err = 1'b0;
    got_q.delete(); rec_q.delete(); stab_viol = 0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 7) == 0) ? HANG_ADDR : 12'h200 + 12'(4 * $urandom_range(0, 7));
      push_cmd(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
      idle($urandom_range(0, 3));
    end
    wait_rsp(24, 3000, "random");
    rand_rdy = 1'b0;
    idle(2);
    rsp_ready = 1'b1;
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_fail++; $display("FAIL random_rsp got %h, expected %h", g, e); end
    end
    n_checks++;
    if (stab_viol != 0 || prot_viol != 0) begin
      n_fail++;
      $display("FAIL random_protocol got stab=%0d prot=%0d, expected 0 0", stab_viol, prot_viol);
    end
    n_checks++;
    if (b_diff != 0) begin n_fail++; $display("FAIL apb3_match got %0d differing cycles, expected 0", b_diff); end
  endtask

  task automatic test_reset_mid_access;
    int k = 0;
    cfg_wait = 0; cfg_err = 1'b0;
    rsp_ready = 1'b0;
    got_q.delete();
    // Phase 1: response pending and a command queued behind it.
    push_cmd(1'b1, 12'h040, $urandom, 4'hF);
    idle(6);
    push_cmd(1'b0, 12'h044, 32'h0, 4'h0);
    idle(2);
    n_checks++;
    if (rsp_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre got rsp_valid=%b busy=%b, expected 1 1", rsp_valid, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rsp got rsp_valid=%b busy=%b cmd_ready=%b, expected 0 0 1", rsp_valid, busy, cmd_ready);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    idle(1);
    // Phase 2: reset in the middle of a stalled ACCESS.
    rsp_ready = 1'b1;
    push_cmd(1'b0, HANG_ADDR, 32'h0, 4'h0);
    while (!(psel && penable) && k < 20) begin idle(1); k++; end
    idle(3);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_access got psel=%b penable=%b rsp_valid=%b busy=%b cmd_ready=%b, expected 0 0 0 0 1",
               psel, penable, rsp_valid, busy, cmd_ready);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); rec_q.delete(); got_q.delete();
    idle(40);
    n_checks++;
    if (got_q.size() != 0 || rec_q.size() != 0 || cur_len != 0) begin
      n_fail++;
      $display("FAIL rst_after got responses=%0d transfers=%0d psel_cycles=%0d, expected 0 0 0",
               got_q.size(), rec_q.size(), cur_len);
    end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    logic [31:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = $urandom;
      mem[i] = v;
      ref_mem[i] = v;
    end
    test_reset();
    test_write_read();
    test_wait_err();
    test_timeout();
    test_backpressure();
    test_apb4_strb();
    test_random();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
